// File: rtl/ad7606_pkg.sv
// Shared types and constants for the AD7606 conversion sequencer.
package ad7606_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic [2:0] {
    RST, IDLE, CONV, WAIT_BH, WAIT_BL, RD_L, RD_H
  } state_e;

  // OS[2:0] pin codes: oversampling ratio 2^code, 3'b111 is invalid on the part.
  localparam logic [2:0] OS_NONE = 3'd0;
  localparam logic [2:0] OS_X2   = 3'd1;
  localparam logic [2:0] OS_X4   = 3'd2;
  localparam logic [2:0] OS_X8   = 3'd3;
  localparam logic [2:0] OS_X16  = 3'd4;
  localparam logic [2:0] OS_X32  = 3'd5;
  localparam logic [2:0] OS_X64  = 3'd6;

  function automatic logic is_last_ch(input logic [CH_W-1:0] ch);
    return ch == CH_W'(NUM_CH - 1);
  endfunction

endpackage

// File: rtl/ad7606_rate_gen.sv
// Conversion-rate generator: free-running period counter with a tick on wrap.
module ad7606_rate_gen #(
  parameter int PERIOD = 2500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == CW'(PERIOD - 1));
    cnt_d = cnt_q + CW'(1);
    if (!enable || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ad7606_seq.sv
// AD7606 sequencer: rate-controlled CONVST, BUSY handshake, 8-channel CS/RD readout.
// Optional first_data framing check enabled by defining AD7606_SEQ_FRMCHK_EN.
module ad7606_seq
  import ad7606_pkg::*;
#(
  parameter int SMP_PERIOD = 2500,
  parameter int CONV_LOW   = 5,
  parameter int RD_LOW     = 3,
  parameter int RD_HIGH    = 2,
  parameter int RST_CYCLES = 50,
  parameter int BUSY_TMO   = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  os_sel,
  input  logic [15:0] ad_data,
  input  logic        ad_busy,
  input  logic        first_data,
  output logic [2:0]  ad_os,
  output logic        ad_cs,
  output logic        ad_rd,
  output logic        ad_reset,
  output logic        ad_convstab,
  output logic [15:0] smp_data,
  output logic [2:0]  smp_ch,
  output logic        smp_valid,
  output logic        smp_last,
  output logic        err_tmo,
  output logic        err_ovr,
  output logic        err_frm
);
  localparam int TW = 16;

  logic tick;

  ad7606_rate_gen #(.PERIOD(SMP_PERIOD)) u_rate (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [2:0]      os_q, os_d;
  logic            cs_q, cs_d, rd_q, rd_d, reset_q, reset_d, conv_q, conv_d;
  logic [15:0]     sdata_q, sdata_d;
  logic [CH_W-1:0] sch_q, sch_d;
  logic            svalid_q, svalid_d, slast_q, slast_d;
  logic            tmo_q, tmo_d, ovr_q, ovr_d;
  logic [1:0]      busy_s_q, busy_s_d;
  logic            busy_sync;

`ifdef AD7606_SEQ_FRMCHK_EN
  logic [1:0] fd_s_q, fd_s_d;
  logic       frm_q, frm_d, restart_q, restart_d;
`endif

  assign busy_sync = busy_s_q[1];

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + TW'(1);
    ch_d     = ch_q;
    os_d     = os_q;
    cs_d     = cs_q;
    rd_d     = rd_q;
    reset_d  = reset_q;
    conv_d   = conv_q;
    sdata_d  = sdata_q;
    sch_d    = sch_q;
    svalid_d = 1'b0;
    slast_d  = 1'b0;
    tmo_d    = tmo_q;
    // A tick outside IDLE is dropped; the running frame is left alone.
    ovr_d    = ovr_q | (tick && state_q != IDLE);
    busy_s_d = {busy_s_q[0], ad_busy};
`ifdef AD7606_SEQ_FRMCHK_EN
    fd_s_d    = {fd_s_q[0], first_data};
    frm_d     = frm_q;
    restart_d = restart_q;
`endif

    case (state_q)
      RST: if (tmr_q == TW'(RST_CYCLES - 1)) begin
        state_d = IDLE;
        reset_d = 1'b0;
        tmr_d   = '0;
      end
      IDLE: begin
        os_d  = os_sel;
        tmr_d = '0;
        if (tick && enable) begin
          state_d = CONV;
          conv_d  = 1'b0;
        end
      end
      CONV: if (tmr_q == TW'(CONV_LOW - 1)) begin
        state_d = WAIT_BH;
        conv_d  = 1'b1;
        tmr_d   = '0;
      end
      WAIT_BH, WAIT_BL: begin
        if ((state_q == WAIT_BH) == busy_sync) begin
          tmr_d = '0;
          if (state_q == WAIT_BH) begin
            state_d = WAIT_BL;
          end else begin
            state_d = RD_L;
            ch_d    = '0;
            cs_d    = 1'b0;
            rd_d    = 1'b0;
          end
        end else if (tmr_q == TW'(BUSY_TMO - 1)) begin
          tmo_d   = 1'b1;
          state_d = RST;
          reset_d = 1'b1;
          tmr_d   = '0;
        end
      end
      RD_L: if (tmr_q == TW'(RD_LOW - 1)) begin
        sdata_d  = ad_data;
        sch_d    = ch_q;
        svalid_d = 1'b1;
        slast_d  = is_last_ch(ch_q);
        rd_d     = 1'b1;
        state_d  = RD_H;
        tmr_d    = '0;
`ifdef AD7606_SEQ_FRMCHK_EN
        if (ch_q == '0) begin
          if (!fd_s_q[1]) begin
            frm_d     = 1'b1;
            restart_d = 1'b1;
          end
        end else if (fd_s_q[1]) begin
          frm_d = 1'b1;
        end
`endif
      end
      RD_H: if (tmr_q == TW'(RD_HIGH - 1)) begin
        tmr_d = '0;
        if (is_last_ch(ch_q)) begin
          cs_d    = 1'b1;
          state_d = IDLE;
`ifdef AD7606_SEQ_FRMCHK_EN
          // Lost frame alignment: re-reset the ADC before the next conversion.
          if (restart_q) begin
            state_d   = RST;
            reset_d   = 1'b1;
            restart_d = 1'b0;
          end
`endif
        end else begin
          ch_d    = ch_q + CH_W'(1);
          rd_d    = 1'b0;
          state_d = RD_L;
        end
      end
      default: begin
        state_d = RST;
        reset_d = 1'b1;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST;
      tmr_q     <= '0;
      ch_q      <= '0;
      os_q      <= '0;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      reset_q   <= 1'b1;
      conv_q    <= 1'b1;
      sdata_q   <= '0;
      sch_q     <= '0;
      svalid_q  <= 1'b0;
      slast_q   <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
      busy_s_q  <= '0;
`ifdef AD7606_SEQ_FRMCHK_EN
      fd_s_q    <= '0;
      frm_q     <= 1'b0;
      restart_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      ch_q      <= ch_d;
      os_q      <= os_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      reset_q   <= reset_d;
      conv_q    <= conv_d;
      sdata_q   <= sdata_d;
      sch_q     <= sch_d;
      svalid_q  <= svalid_d;
      slast_q   <= slast_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
      busy_s_q  <= busy_s_d;
`ifdef AD7606_SEQ_FRMCHK_EN
      fd_s_q    <= fd_s_d;
      frm_q     <= frm_d;
      restart_q <= restart_d;
`endif
    end
  end

`ifdef AD7606_SEQ_FRMCHK_EN
  assign err_frm = frm_q;
`else
  logic unused_fd;
  assign unused_fd = first_data;
  assign err_frm   = 1'b0;
`endif

  assign ad_os       = os_q;
  assign ad_cs       = cs_q;
  assign ad_rd       = rd_q;
  assign ad_reset    = reset_q;
  assign ad_convstab = conv_q;
  assign smp_data    = sdata_q;
  assign smp_ch      = sch_q;
  assign smp_valid   = svalid_q;
  assign smp_last    = slast_q;
  assign err_tmo     = tmo_q;
  assign err_ovr     = ovr_q;

endmodule

// File: tb/tb_ad7606_seq.sv
// Bench for ad7606_seq: instance 0 at the default 2500-cycle period, instance 1 at 64
// cycles (overrun); each has a behavioural AD7606 with random data and BUSY length.
module tb_ad7606_seq;

`ifdef AD7606_SEQ_FRMCHK_EN
  localparam logic FRM_EN = 1'b1;
`else
  localparam logic FRM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] os_sel = 3'b000;
  logic enable [2] = '{1'b0, 1'b0};

  logic [15:0] ad_data [2];
  logic        busy [2], first_data [2];
  logic [2:0]  os [2];
  logic        cs [2], rd [2], areset [2], conv [2];
  logic [15:0] sdata [2];
  logic [2:0]  sch [2];
  logic        svalid [2], slast [2], etmo [2], eovr [2], efrm [2];

  int ntests = 0;
  int nfail  = 0;

  // ADC model state
  int          cyc = 0;
  int          rd_idx [2]    = '{0, 0};
  int          busy_cnt [2]  = '{0, 0};
  int          busy_len [2]  = '{100, 200};
  int          busy_jit [2]  = '{200, 0};
  logic [15:0] base [2]      = '{16'h1000, 16'h1000};
  logic        fd_bad [2]    = '{1'b0, 1'b0};
  logic        prev_conv [2] = '{1'b1, 1'b1};
  logic        prev_rd [2]   = '{1'b1, 1'b1};

  // Scoreboard state
  int   scnt [2]   = '{0, 0};
  int   frames [2] = '{0, 0};
  int   ovl [2]    = '{0, 0};
  logic mon_conv [2] = '{1'b1, 1'b1};
  int   conv_t [$];

  always #10 clk = ~clk;

  ad7606_seq u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable[0]), .os_sel(os_sel),
    .ad_data(ad_data[0]), .ad_busy(busy[0]), .first_data(first_data[0]),
    .ad_os(os[0]), .ad_cs(cs[0]), .ad_rd(rd[0]), .ad_reset(areset[0]),
    .ad_convstab(conv[0]), .smp_data(sdata[0]), .smp_ch(sch[0]),
    .smp_valid(svalid[0]), .smp_last(slast[0]), .err_tmo(etmo[0]),
    .err_ovr(eovr[0]), .err_frm(efrm[0])
  );

  ad7606_seq #(.SMP_PERIOD(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .enable(enable[1]), .os_sel(os_sel),
    .ad_data(ad_data[1]), .ad_busy(busy[1]), .first_data(first_data[1]),
    .ad_os(os[1]), .ad_cs(cs[1]), .ad_rd(rd[1]), .ad_reset(areset[1]),
    .ad_convstab(conv[1]), .smp_data(sdata[1]), .smp_ch(sch[1]),
    .smp_valid(svalid[1]), .smp_last(slast[1]), .err_tmo(etmo[1]),
    .err_ovr(eovr[1]), .err_frm(efrm[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // AD7606 behaviour: BUSY after CONVST rises, channel k presents base+k, FRSTDATA on ch0.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ad_data[i]    = base[i] + 16'(rd_idx[i]);
      busy[i]       = busy_cnt[i] != 0;
      first_data[i] = (rd_idx[i] == 0) && !fd_bad[i];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      prev_conv[i] <= conv[i];
      prev_rd[i]   <= rd[i];
      if (prev_conv[i] && !conv[i]) begin
        rd_idx[i] <= 0;
        base[i]   <= 16'($urandom);
      end else if (!prev_rd[i] && rd[i]) begin
        rd_idx[i] <= rd_idx[i] + 1;
      end
      if (!prev_conv[i] && conv[i] && busy_len[i] != 0)
        busy_cnt[i] <= busy_len[i] + int'($urandom_range(0, busy_jit[i]));
      else if (busy_cnt[i] != 0)
        busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end

  // Every strobe must be channel (n mod 8) of a frame carrying base+ch.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (svalid[i]) begin
          int k;
          k = scnt[i] % 8;
          chk($sformatf("smp_data%0d", i), 32'(sdata[i]), 32'(16'(base[i] + 16'(k))));
          chk($sformatf("smp_ch%0d", i), 32'(sch[i]), 32'(k));
          chk($sformatf("smp_last%0d", i), 32'(slast[i]), 32'(k == 7));
          scnt[i] <= scnt[i] + 1;
          if (k == 7) frames[i] <= frames[i] + 1;
        end
        if (!conv[i] && !cs[i]) ovl[i] <= ovl[i] + 1;
        mon_conv[i] <= conv[i];
        if (i == 0 && mon_conv[i] && !conv[i]) conv_t.push_back(cyc);
      end
    end
  end

  task automatic wait_frames(input int i, input int n, input int budget);
    int tgt, c;
    tgt = frames[i] + n;
    c = 0;
    while (frames[i] < tgt && c < budget) begin
      @(posedge clk); #1; c++;
    end
    chk($sformatf("frames_wait%0d", i), 32'(frames[i] >= tgt), 32'd1);
  endtask

  task automatic wait_conv0(input logic lvl, input int budget);
    int c;
    c = 0;
    while (conv[0] !== lvl && c < budget) begin
      @(posedge clk); #1; c++;
    end
    chk("conv_wait", 32'(conv[0]), 32'(lvl));
  endtask

  initial begin
    int n, f;
    logic seen;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f;
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_pins%0d", i), 32'({areset[i], cs[i], rd[i], conv[i], os[i]}), 32'h78);
      chk($sformatf("rst_smp%0d", i), 32'({sdata[i], sch[i], svalid[i], slast[i]}), 32'd0);
      chk($sformatf("rst_err%0d", i), 32'({etmo[i], eovr[i], efrm[i]}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (areset[0] && n < 200);
    chk("rst_pulse_len", 32'(n), 32'd50);
    chk("idle_pins", 32'({cs[0], rd[0], conv[0], areset[0]}), 32'b1110);
    chk("no_valid_in_rst", 32'(scnt[0] + scnt[1]), 32'd0);

    // Normal frames, random data and BUSY length; CONVST spacing is the period
    enable[0] = 1'b1;
    enable[1] = 1'b1;
    wait_frames(0, 3, 9000);
    chk("conv_count", 32'(conv_t.size() >= 3), 32'd1);
    if (conv_t.size() >= 3) begin
      chk("period_a", 32'(conv_t[1] - conv_t[0]), 32'd2500);
      chk("period_b", 32'(conv_t[2] - conv_t[1]), 32'd2500);
    end

    // os_sel change during a frame only reaches the pins back in IDLE
    wait_conv0(1'b0, 3000);
    os_sel = 3'b011;
    n = 0;
    while (cs[0] !== 1'b0 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("os_hold_read", 32'(os[0]), 32'd0);
    wait_frames(0, 1, 3000);
    chk("os_hold_end", 32'(os[0]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("os_update", 32'(os[0]), 32'd3);

    // BUSY never rises: timeout, ADC re-reset, then normal operation
    busy_len[0] = 0;
    wait_conv0(1'b0, 3000);
    wait_conv0(1'b1, 20);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!etmo[0] && n < 700);
    chk("tmo_delay", 32'(n), 32'd500);
    chk("tmo_reset", 32'(areset[0]), 32'd1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (areset[0] && n < 200);
    chk("tmo_rst_len", 32'(n), 32'd50);
    busy_len[0] = 100;
    wait_frames(0, 1, 4000);
    chk("tmo_sticky", 32'(etmo[0]), 32'd1);

    // Overrun instance: stop mid-stream, it must finish the frame and then stay idle
    repeat ($urandom_range(0, 63)) @(posedge clk);
    enable[1] = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    f = frames[1];
    repeat (300) @(posedge clk);
    #1;
    chk("ovr_frames_ran", 32'(f >= 3), 32'd1);
    chk("ovr_stopped", 32'(frames[1]), 32'(f));
    chk("ovr_whole_frames", 32'(scnt[1]), 32'(8 * f));
    chk("ovr_idle_cs", 32'(cs[1]), 32'd1);
    chk("err_ovr64", 32'(eovr[1]), 32'd1);
    chk("err_ovr2500", 32'(eovr[0]), 32'd0);
    chk("no_overlap", 32'(ovl[0] + ovl[1]), 32'd0);
    chk("err_tmo64", 32'(etmo[1]), 32'd0);

    // Missing FRSTDATA on ch0
    fd_bad[0] = 1'b1;
    wait_frames(0, 1, 3000);
    fd_bad[0] = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (areset[0]) seen = 1'b1;
    end
    chk("frm_err", 32'(efrm[0]), 32'(FRM_EN));
    chk("frm_restart", 32'(seen), 32'(FRM_EN));
    wait_frames(0, 1, 4000);
    chk("frm_sticky", 32'(efrm[0]), 32'(FRM_EN));
    chk("frm_err64", 32'(efrm[1]), 32'd0);
    chk("whole_frames0", 32'(scnt[0]), 32'(8 * frames[0]));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/ad7606_seq.md
Name: ad7606_seq

Overview:
- Timing sequencer for the AD7606 8-channel parallel ADC.
- Generates conversion starts at a programmable sample rate and runs the BUSY handshake.
- Reads all 8 channels with CS/RD strobes and emits them as a 16-bit sample stream.
- Sits between the ADC pins and the voltage-conversion, filter and UART datapath, replacing the free-running reader with a rate-controlled, error-reporting one.

Parameters:
- SMP_PERIOD, 2500: clk cycles per conversion frame (20 kHz at 50 MHz); minimum 64.
- CONV_LOW, 5: cycles ad_convstab is held low.
- RD_LOW, 3: cycles ad_rd is held low per channel; data is captured on the last low cycle.
- RD_HIGH, 2: cycles ad_rd is held high between channels.
- RST_CYCLES, 50: cycles ad_reset is held high.
- BUSY_TMO, 500: maximum cycles waited for each BUSY edge.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run conversions while high
- os_sel  in  3  oversampling ratio, latched in IDLE
- ad_data  in  16  ADC parallel data bus
- ad_busy  in  1  ADC BUSY
- first_data  in  1  ADC FRSTDATA flag
- ad_os  out  3  ADC OS[2:0] pins
- ad_cs  out  1  ADC chip select, active low
- ad_rd  out  1  ADC read strobe, active low
- ad_reset  out  1  ADC reset, active high
- ad_convstab  out  1  ADC CONVST A/B, pulses low
- smp_data  out  16  captured sample, two's complement
- smp_ch  out  3  channel index of smp_data, 0..7
- smp_valid  out  1  one-cycle strobe, sample valid
- smp_last  out  1  high with smp_valid on channel 7
- err_tmo  out  1  sticky: BUSY timeout occurred
- err_ovr  out  1  sticky: period tick arrived while a frame was in progress
- err_frm  out  1  sticky: first_data mismatch (optional feature only)

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset values:
  - ad_cs=1, ad_rd=1, ad_convstab=1, ad_reset=1, ad_os=0
  - smp_* = 0
  - all err_* = 0
  - state=RST, period counter=0
- Period counter:
  - Runs 0..SMP_PERIOD-1 while enable=1 and wraps; tick at wrap.
  - Held at 0 while enable=0.
- States and transitions:
  - RST: ad_reset=1 for RST_CYCLES cycles, then IDLE.
  - IDLE: latch os_sel into ad_os. On tick with enable=1, go to CONV.
  - CONV: ad_convstab=0 for CONV_LOW cycles, then drive 1 and go to WAIT_BH.
  - WAIT_BH: wait for ad_busy=1.
  - WAIT_BL: wait for ad_busy=0, then go to RD_L with ch=0.
  - RD_L: ad_cs=0, ad_rd=0 for RD_LOW cycles. On the last cycle register ad_data into smp_data, set smp_ch=ch, pulse smp_valid for 1 cycle; smp_last=(ch==7).
  - RD_H: ad_cs=0, ad_rd=1 for RD_HIGH cycles. If ch<7: ch+1, back to RD_L. If ch=7: ad_cs=1, go to IDLE.
- BUSY timeout: in WAIT_BH or WAIT_BL, if BUSY_TMO cycles elapse without the expected edge, set err_tmo and go to RST (ADC is re-reset).
- Overrun: a tick while state is not IDLE sets err_ovr. That tick is dropped; the current frame completes normally.
- enable falling mid-frame: the frame completes, then the block stays in IDLE.
- ad_os changes only in IDLE, never during a conversion.
- err_* bits clear only on reset.
- Latency: smp_valid for ch0 occurs at CONV_LOW + BUSY time + RD_LOW cycles after the tick.
- Full frame takes CONV_LOW + BUSY time + 8·(RD_LOW+RD_HIGH) cycles.
- ad_busy and first_data pass through 2-flop synchronisers before use; ad_data is sampled directly, stable by the end of RD_L.

Optional Feature:
- Macro: AD7606_SEQ_FRMCHK_EN.
- Defined:
  - first_data is synchronised and sampled with the ch0 capture.
  - first_data must be 1 at ch0 and 0 at ch1..7; any mismatch sets err_frm.
  - A ch0 mismatch also forces the next frame to start from RST.
- Undefined: err_frm is tied 0 and first_data is ignored.

Decomposition:
- Package ad7606_pkg holds:
  - state enum (RST, IDLE, CONV, WAIT_BH, WAIT_BL, RD_L, RD_H)
  - NUM_CH=8
  - OS ratio constants
- One sub-module, ad7606_rate_gen: period counter plus tick, with enable.
- Everything else stays in a single FSM.

Test Plan:
- Reset release: ad_reset=1 for 50 cycles → IDLE; ad_cs=ad_rd=ad_convstab=1; no smp_valid.
- enable=1, ADC model BUSY high 200 cycles, data ch k = 16'h1000+k → 8 strobes with smp_ch 0..7 and data 16'h1000..16'h1007. smp_last only on ch7. Frames spaced exactly 2500 cycles.
- BUSY never rises → err_tmo=1 at 500 cycles after CONV end; ad_reset pulses 50 cycles; the next tick converts normally.
- SMP_PERIOD=64 with BUSY 200 cycles → err_ovr=1; every frame still yields 8 samples; no RD/CONVST overlap.
- os_sel changed from 3'b000 to 3'b011 mid-frame → ad_os updates only after the frame returns to IDLE.
- With AD7606_SEQ_FRMCHK_EN, first_data=0 at ch0 → err_frm=1 and the next frame starts via RST. Without the macro, err_frm stays 0.
